// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL dynamic reconfiguration controller.
//   pll_state_t  : controller FSM states
//   pll_div_t    : the five PLL divider selects carried as one packed word
//   div_has_zero : true when any divider in a set is zero (an invalid request)
package pll_cfg_pkg;

  localparam int IDIV_W  = 6;
  localparam int FBDIV_W = 6;
  localparam int MDIV_W  = 7;
  localparam int ODIV_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_APPLY     = 2'd1,
    ST_RESET     = 2'd2,
    ST_WAIT_LOCK = 2'd3
  } pll_state_t;

  typedef struct packed {
    logic [IDIV_W-1:0]  idiv;
    logic [FBDIV_W-1:0] fbdiv;
    logic [MDIV_W-1:0]  mdiv;
    logic [ODIV_W-1:0]  odiv0;
    logic [ODIV_W-1:0]  odiv1;
  } pll_div_t;

  function automatic logic div_has_zero(input pll_div_t d);
    return (d.idiv == '0) || (d.fbdiv == '0) || (d.mdiv == '0) ||
           (d.odiv0 == '0) || (d.odiv1 == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for a level signal that is asynchronous
// to clk.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_dyn_cfg.sv
// Run-time reconfiguration controller for the fabric PLL. Accepts a divider
// set over valid/ready, drives the PLL select ports, pulses the PLL reset,
// then waits for a stable lock and reports done or timeout.
//   clk, rst                 : reference clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_idiv .. req_odiv1    : requested divider values (0 is rejected)
//   pll_idsel .. pll_odsel1  : registered selects to the PLL
//   pll_reset                : PLL reset, high for RESET_CYCLES per request
//   pll_lock                 : raw PLL lock, asynchronous to clk
//   busy, locked             : status levels
//   done, err, lock_lost     : one-cycle event pulses
module pll_dyn_cfg
  import pll_cfg_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int DEF_IDIV      = 1,
  parameter int DEF_FBDIV     = 1,
  parameter int DEF_MDIV      = 16,
  parameter int DEF_ODIV0     = 8,
  parameter int DEF_ODIV1     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDIV_W-1:0]  req_idiv,
  input  logic [FBDIV_W-1:0] req_fbdiv,
  input  logic [MDIV_W-1:0]  req_mdiv,
  input  logic [ODIV_W-1:0]  req_odiv0,
  input  logic [ODIV_W-1:0]  req_odiv1,
  output logic [IDIV_W-1:0]  pll_idsel,
  output logic [FBDIV_W-1:0] pll_fbdsel,
  output logic [MDIV_W-1:0]  pll_mdsel,
  output logic [ODIV_W-1:0]  pll_odsel0,
  output logic [ODIV_W-1:0]  pll_odsel1,
  output logic               pll_reset,
  input  logic               pll_lock,
  output logic               busy,
  output logic               locked,
  output logic               done,
  output logic               err,
  output logic               lock_lost
);

  localparam int RST_W    = $clog2(RESET_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RST_W-1:0]    RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(LOCK_TIMEOUT);

  pll_state_t          state_reg;
  pll_div_t            div_reg;
  pll_div_t            req_div;
  logic                pll_reset_reg;
  logic                req_ready_reg;
  logic                busy_reg;
  logic                locked_reg;
  logic                done_reg;
  logic                err_reg;
  logic                lock_lost_reg;
  logic [RST_W-1:0]    rst_cnt_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic [SETTLE_W-1:0] settle_next;
  logic [TMO_W-1:0]    tmo_reg;
  logic [TMO_W-1:0]    tmo_next;
  logic                lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign req_div = '{idiv: req_idiv, fbdiv: req_fbdiv, mdiv: req_mdiv,
                     odiv0: req_odiv0, odiv1: req_odiv1};

  // Saturating counters: settle restarts on any low lock sample.
  always_comb begin
    settle_next = '0;
    tmo_next    = (tmo_reg == TMO_MAX) ? tmo_reg : tmo_reg + 1'b1;
    if (lock_s) begin
      settle_next = (settle_reg == SETTLE_MAX) ? settle_reg : settle_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      div_reg.idiv  <= IDIV_W'(DEF_IDIV);
      div_reg.fbdiv <= FBDIV_W'(DEF_FBDIV);
      div_reg.mdiv  <= MDIV_W'(DEF_MDIV);
      div_reg.odiv0 <= ODIV_W'(DEF_ODIV0);
      div_reg.odiv1 <= ODIV_W'(DEF_ODIV1);
      pll_reset_reg <= 1'b0;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      locked_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      lock_lost_reg <= 1'b0;
      rst_cnt_reg   <= '0;
      settle_reg    <= '0;
      tmo_reg       <= '0;
    end else begin
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      lock_lost_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (locked_reg && !lock_s) begin
            locked_reg    <= 1'b0;
            lock_lost_reg <= 1'b1;
          end
          if (req_valid && req_ready_reg) begin
            if (div_has_zero(req_div)) begin
              err_reg <= 1'b1;
            end else begin
              div_reg       <= req_div;
              state_reg     <= ST_APPLY;
              req_ready_reg <= 1'b0;
              busy_reg      <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          // Selects have been stable for a cycle; start the reset pulse.
          state_reg     <= ST_RESET;
          pll_reset_reg <= 1'b1;
          rst_cnt_reg   <= '0;
          locked_reg    <= 1'b0;
        end
        ST_RESET: begin
          locked_reg <= 1'b0;
          if (rst_cnt_reg == RST_LAST) begin
            pll_reset_reg <= 1'b0;
            state_reg     <= ST_WAIT_LOCK;
            settle_reg    <= '0;
            tmo_reg       <= '0;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          settle_reg <= settle_next;
          tmo_reg    <= tmo_next;
          // Settle is checked first so a simultaneous timeout reports done.
          if (settle_next == SETTLE_MAX) begin
            done_reg      <= 1'b1;
            locked_reg    <= 1'b1;
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else if (tmo_next == TMO_MAX) begin
            err_reg       <= 1'b1;
            locked_reg    <= 1'b0;
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          pll_reset_reg <= 1'b0;
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign busy       = busy_reg;
  assign locked     = locked_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign lock_lost  = lock_lost_reg;
  assign pll_reset  = pll_reset_reg;
  assign pll_idsel  = div_reg.idiv;
  assign pll_fbdsel = div_reg.fbdiv;
  assign pll_mdsel  = div_reg.mdiv;
  assign pll_odsel0 = div_reg.odiv0;
  assign pll_odsel1 = div_reg.odiv1;

endmodule

// File: tb/tb_pll_dyn_cfg.sv
// Directed bench for pll_dyn_cfg: a vector table of requests plus
// hand-written sequences for lock timing, timeout, glitch, lock loss and
// mid-sequence reset.
module tb_pll_dyn_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_idiv, req_fbdiv;
  logic [6:0] req_mdiv, req_odiv0, req_odiv1;
  logic [5:0] pll_idsel, pll_fbdsel;
  logic [6:0] pll_mdsel, pll_odsel0, pll_odsel1;
  logic       pll_reset, pll_lock, busy, locked, done, err, lock_lost;

  pll_dyn_cfg #(
    .RESET_CYCLES (16),
    .SETTLE_CYCLES(64),
    .LOCK_TIMEOUT (200)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv(req_idiv), .req_fbdiv(req_fbdiv), .req_mdiv(req_mdiv),
    .req_odiv0(req_odiv0), .req_odiv1(req_odiv1),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_mdsel(pll_mdsel),
    .pll_odsel0(pll_odsel0), .pll_odsel1(pll_odsel1),
    .pll_reset(pll_reset), .pll_lock(pll_lock),
    .busy(busy), .locked(locked), .done(done), .err(err), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [6:0] mdiv;
    logic [6:0] odiv0;
    logic [6:0] odiv1;
    bit         accept;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-window tallies filled by watch()
  int rst_hi, rst_first, rst_last;
  int done_cnt, done_cyc, err_cnt, err_cyc, lost_cnt, lost_cyc;

  logic [32:0] exp_sel;
  logic [32:0] def_sel;
  int          n_req;

  function automatic logic [32:0] cur_sel();
    return {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel0, pll_odsel1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    rst_hi = 0; rst_first = -1; rst_last = -1;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    lost_cnt = 0; lost_cyc = -1;
  endtask

  // Steps n cycles, driving pll_lock at up to two absolute cycles, and
  // tallies the pulse outputs seen in each cycle.
  task automatic watch(input int n, input int e0, input logic v0,
                       input int e1, input logic v1);
    for (int i = 0; i < n; i++) begin
      step();
      if (cyc == e0) pll_lock = v0;
      if (cyc == e1) pll_lock = v1;
      if (pll_reset) begin
        rst_hi++;
        if (rst_first < 0) rst_first = cyc;
        rst_last = cyc;
      end
      if (done)      begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (err)       begin err_cnt++;  if (err_cyc < 0)  err_cyc  = cyc; end
      if (lock_lost) begin lost_cnt++; if (lost_cyc < 0) lost_cyc = cyc; end
    end
  endtask

  // Presents a request for one cycle; returns the accept cycle N.
  task automatic send(input logic [5:0] i, input logic [5:0] f, input logic [6:0] m,
                      input logic [6:0] o0, input logic [6:0] o1, output int n);
    req_idiv = i; req_fbdiv = f; req_mdiv = m; req_odiv0 = o0; req_odiv1 = o1;
    req_valid = 1'b1;
    n = cyc;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{6'd1,  6'd1,  7'd20,  7'd10,  7'd5,   1'b1};
    vecs[1] = '{6'd0,  6'd1,  7'd16,  7'd8,   7'd4,   1'b0};
    vecs[2] = '{6'd1,  6'd0,  7'd16,  7'd8,   7'd4,   1'b0};
    vecs[3] = '{6'd1,  6'd1,  7'd0,   7'd8,   7'd4,   1'b0};
    vecs[4] = '{6'd2,  6'd3,  7'd40,  7'd0,   7'd7,   1'b0};
    vecs[5] = '{6'd1,  6'd1,  7'd1,   7'd1,   7'd0,   1'b0};
    vecs[6] = '{6'd63, 6'd63, 7'd127, 7'd127, 7'd127, 1'b1};
    vecs[7] = '{6'd3,  6'd2,  7'd50,  7'd6,   7'd12,  1'b1};
    def_sel = {6'd1, 6'd1, 7'd16, 7'd8, 7'd4};

    // ---------------- reset with pll_lock high ----------------
    rst = 1'b1; pll_lock = 1'b1; req_valid = 1'b0;
    req_idiv = '0; req_fbdiv = '0; req_mdiv = '0; req_odiv0 = '0; req_odiv1 = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_selects", cur_sel(), def_sel);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_locked", locked, 0);
    chk("reset_pll_reset", pll_reset, 0);
    clr();
    watch(5, -1, 1'b0, -1, 1'b0);
    chk("reset_no_pulses", done_cnt + err_cnt + lost_cnt + rst_hi, 0);
    chk("reset_locked_stays0", locked, 0);
    $display("txn reset: selects=%h ready=%0d", cur_sel(), req_ready);

    // ---------------- main request, lock arrives at N+10 ----------------
    pll_lock = 1'b0;
    repeat (3) step();
    send(6'd1, 6'd1, 7'd20, 7'd10, 7'd5, n_req);
    exp_sel = {6'd1, 6'd1, 7'd20, 7'd10, 7'd5};
    chk("main_sel_n1", cur_sel(), exp_sel);
    chk("main_busy_n1", busy, 1);
    chk("main_ready_n1", req_ready, 0);
    chk("main_rst_n1", pll_reset, 0);
    clr();
    watch(110, n_req + 10, 1'b1, -1, 1'b0);
    chk("main_rst_first", rst_first, n_req + 2);
    chk("main_rst_len", rst_hi, 16);
    chk("main_rst_last", rst_last, n_req + 17);
    chk("main_done_cnt", done_cnt, 1);
    chk("main_done_cyc", done_cyc, n_req + 82);
    chk("main_err_cnt", err_cnt, 0);
    chk("main_locked", locked, 1);
    chk("main_ready_end", req_ready, 1);
    $display("txn main: N=%0d done@%0d rst_len=%0d", n_req, done_cyc, rst_hi);

    // ---------------- vector table (pll_lock held high) ----------------
    for (int v = 0; v < 8; v++) begin
      logic [32:0] prev;
      prev = cur_sel();
      send(vecs[v].idiv, vecs[v].fbdiv, vecs[v].mdiv, vecs[v].odiv0, vecs[v].odiv1, n_req);
      if (vecs[v].accept) begin
        exp_sel = {vecs[v].idiv, vecs[v].fbdiv, vecs[v].mdiv, vecs[v].odiv0, vecs[v].odiv1};
        chk("vec_sel", cur_sel(), exp_sel);
        chk("vec_busy", busy, 1);
        chk("vec_err", err, 0);
        clr();
        watch(100, -1, 1'b0, -1, 1'b0);
        chk("vec_rst_len", rst_hi, 16);
        chk("vec_done_cyc", done_cyc, n_req + 82);
        chk("vec_done_cnt", done_cnt, 1);
        chk("vec_no_err_lost", err_cnt + lost_cnt, 0);
        chk("vec_locked", locked, 1);
      end else begin
        chk("vec_rej_err", err, 1);
        chk("vec_rej_busy", busy, 0);
        chk("vec_rej_sel", cur_sel(), prev);
        clr();
        watch(5, -1, 1'b0, -1, 1'b0);
        chk("vec_rej_quiet", rst_hi + err_cnt + done_cnt, 0);
        chk("vec_rej_ready", req_ready, 1);
      end
      $display("txn vec%0d: req=%0d/%0d/%0d/%0d/%0d accept=%0d sel=%h",
               v, vecs[v].idiv, vecs[v].fbdiv, vecs[v].mdiv, vecs[v].odiv0,
               vecs[v].odiv1, vecs[v].accept, cur_sel());
    end

    // ---------------- lock lost while idle ----------------
    clr();
    n_req = cyc;
    pll_lock = 1'b0;
    watch(6, -1, 1'b0, -1, 1'b0);
    chk("lost_cnt", lost_cnt, 1);
    chk("lost_cyc", lost_cyc, n_req + 3);
    chk("lost_locked", locked, 0);
    $display("txn lock_lost: drop@%0d pulse@%0d", n_req, lost_cyc);

    // ---------------- timeout with pll_lock low ----------------
    send(6'd2, 6'd2, 7'd30, 7'd6, 7'd3, n_req);
    clr();
    watch(240, -1, 1'b0, -1, 1'b0);
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_err_cyc", err_cyc, n_req + 218);
    chk("tmo_done_cnt", done_cnt, 0);
    chk("tmo_rst_len", rst_hi, 16);
    chk("tmo_locked", locked, 0);
    chk("tmo_ready", req_ready, 1);
    chk("tmo_pll_reset", pll_reset, 0);
    chk("tmo_sel_kept", cur_sel(), {6'd2, 6'd2, 7'd30, 7'd6, 7'd3});
    $display("txn timeout: N=%0d err@%0d", n_req, err_cyc);

    // ---------------- one-cycle lock glitch at settle count 30 ----------------
    pll_lock = 1'b1;
    repeat (3) step();
    send(6'd1, 6'd2, 7'd24, 7'd12, 7'd6, n_req);
    clr();
    watch(140, n_req + 46, 1'b0, n_req + 47, 1'b1);
    chk("glitch_done_cnt", done_cnt, 1);
    chk("glitch_done_cyc", done_cyc, n_req + 113);
    chk("glitch_err_cnt", err_cnt, 0);
    chk("glitch_locked", locked, 1);
    $display("txn glitch: N=%0d done@%0d", n_req, done_cyc);

    // ---------------- rst in the middle of RESET ----------------
    send(6'd4, 6'd4, 7'd60, 7'd9, 7'd9, n_req);
    repeat (4) step();
    chk("midrst_pll_reset_before", pll_reset, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pll_reset", pll_reset, 0);
    chk("midrst_sel_def", cur_sel(), def_sel);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_locked", locked, 0);
    step();
    send(6'd1, 6'd1, 7'd20, 7'd10, 7'd5, n_req);
    chk("midrst_req_busy", busy, 1);
    clr();
    watch(100, -1, 1'b0, -1, 1'b0);
    chk("midrst_rst_len", rst_hi, 16);
    chk("midrst_done_cyc", done_cyc, n_req + 82);
    chk("midrst_locked_end", locked, 1);
    $display("txn midrst: N=%0d done@%0d", n_req, done_cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
